// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the registered sequential ALU (alu_seq):
//   - opcode encodings OP_ADD .. OP_MUL
//   - control state encoding (IDLE / BUSY / DONE)
//   - bit positions of N, Z, C, V inside the 4-bit ALUFlags vector
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_EOR = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSB = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_addsub.sv
// ---------------------------------------------------------------------------
// alu_seq_addsub
// Combinational WIDTH+1-bit adder shared by ADD/SUB/ADC/SBC/RSB.
// Either operand may be bit-inverted before the add; subtraction is formed as
// x + ~y + cin, so C=1 means "no borrow".
// Ports:
//   i_a, i_b   WIDTH-bit operands
//   i_inv_a    invert A before the add (RSB)
//   i_inv_b    invert B before the add (SUB/SBC)
//   i_cin      carry into bit 0
//   o_sum      WIDTH-bit sum
//   o_c        carry out (bit WIDTH of the extended sum)
//   o_v        signed overflow of the post-inversion operands
// ---------------------------------------------------------------------------
module alu_seq_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_inv_a,
  input  logic             i_inv_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_c,
  output logic             o_v
);

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH:0]   w_ext;

  assign w_x   = i_inv_a ? ~i_a : i_a;
  assign w_y   = i_inv_b ? ~i_b : i_b;
  assign w_ext = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, i_cin};

  assign o_sum = w_ext[WIDTH-1:0];
  assign o_c   = w_ext[WIDTH];
  // Overflow: both adder inputs share a sign and the sum's sign differs.
  assign o_v   = (w_x[WIDTH-1] == w_y[WIDTH-1]) & (w_ext[WIDTH-1] != w_x[WIDTH-1]);

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Registered ALU with valid/ready handshakes on both sides and NZCV flags.
// Single-cycle ops produce a result one cycle after accept; back-to-back
// accepts are possible while the consumer keeps Out_Ready high.
// Optional iterative multiply (opcode 1000) is built only when the macro
// ALU_SEQ_MUL_EN is defined; otherwise 1000 behaves as an illegal opcode.
// Ports:
//   CLK, RESET_N      clock (rising edge), asynchronous active-low reset
//   In_Valid/In_Ready operand handshake
//   Src_A, Src_B      WIDTH-bit operands
//   ALUControl        4-bit opcode
//   Flag_C_in         current C flag (ADC/SBC carry, logic/MUL C pass-through)
//   Out_Valid/Out_Ready result handshake
//   ALUResult         registered result
//   ALUFlags          registered {N,Z,C,V}
//   Op_Illegal        result belongs to an undefined opcode
// ---------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Src_A,
  input  logic [WIDTH-1:0] Src_B,
  input  logic [3:0]       ALUControl,
  input  logic             Flag_C_in,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags,
  output logic             Op_Illegal
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 4) begin : g_width_check
    $error("alu_seq: WIDTH must be at least 4");
  end
  if (CNT_W <= $clog2(WIDTH)) begin : g_cnt_check
    $error("alu_seq: CNT_W too narrow to count WIDTH iterations");
  end

  alu_state_e       r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_illegal;

  logic             w_in_ready;
  logic             w_accept;

  logic             w_inv_a;
  logic             w_inv_b;
  logic             w_cin;
  logic [WIDTH-1:0] w_sum;
  logic             w_add_c;
  logic             w_add_v;

  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_illegal;
  logic [3:0]       w_flags;

`ifdef ALU_SEQ_MUL_EN
  logic             w_is_mul;
  logic [WIDTH-1:0] r_mul_a;
  logic [WIDTH-1:0] r_mul_b;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mul_cin;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_mul_last;
  logic [3:0]       w_mul_flags;
`endif

  // A new operand set can enter when idle, or when the presented result is
  // being taken in this same cycle.
  assign w_in_ready = (r_state == ST_IDLE) | ((r_state == ST_DONE) & Out_Ready);
  assign w_accept   = In_Valid & w_in_ready;

  // Adder operand steering for the arithmetic opcodes.
  always_comb begin
    w_inv_a = 1'b0;
    w_inv_b = 1'b0;
    w_cin   = 1'b0;
    case (ALUControl)
      OP_SUB: begin
        w_inv_b = 1'b1;
        w_cin   = 1'b1;
      end
      OP_ADC: begin
        w_cin   = Flag_C_in;
      end
      OP_SBC: begin
        w_inv_b = 1'b1;
        w_cin   = Flag_C_in;
      end
      OP_RSB: begin
        w_inv_a = 1'b1;
        w_cin   = 1'b1;
      end
      default: begin
        w_cin   = 1'b0;
      end
    endcase
  end

  alu_seq_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .i_a     (Src_A),
    .i_b     (Src_B),
    .i_inv_a (w_inv_a),
    .i_inv_b (w_inv_b),
    .i_cin   (w_cin),
    .o_sum   (w_sum),
    .o_c     (w_add_c),
    .o_v     (w_add_v)
  );

  // Single-cycle result select; logic and illegal ops pass C through.
  always_comb begin
    w_res     = {WIDTH{1'b0}};
    w_c       = Flag_C_in;
    w_v       = 1'b0;
    w_illegal = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    w_is_mul  = 1'b0;
`endif
    case (ALUControl)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_RSB: begin
        w_res = w_sum;
        w_c   = w_add_c;
        w_v   = w_add_v;
      end
      OP_AND: w_res = Src_A & Src_B;
      OP_ORR: w_res = Src_A | Src_B;
      OP_EOR: w_res = Src_A ^ Src_B;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: w_is_mul = 1'b1;
`else
      OP_MUL: w_illegal = 1'b1;
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  // NZCV for the single-cycle path (an illegal op yields result 0, so Z=1).
  always_comb begin
    w_flags         = 4'b0000;
    w_flags[FLAG_N] = w_res[WIDTH-1];
    w_flags[FLAG_Z] = (w_res == {WIDTH{1'b0}});
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_V] = w_v;
  end

`ifdef ALU_SEQ_MUL_EN
  // One shift-add step: add the shifted multiplicand when the current B bit is set.
  assign w_acc_next = r_acc + (r_mul_b[0] ? r_mul_a : {WIDTH{1'b0}});
  assign w_mul_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Flags of the final multiply product.
  always_comb begin
    w_mul_flags         = 4'b0000;
    w_mul_flags[FLAG_N] = w_acc_next[WIDTH-1];
    w_mul_flags[FLAG_Z] = (w_acc_next == {WIDTH{1'b0}});
    w_mul_flags[FLAG_C] = r_mul_cin;
    w_mul_flags[FLAG_V] = 1'b0;
  end

  // Multiply datapath: operands captured at accept, one B bit consumed per BUSY cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mul_a   <= {WIDTH{1'b0}};
      r_mul_b   <= {WIDTH{1'b0}};
      r_acc     <= {WIDTH{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_mul_cin <= 1'b0;
    end else if (w_accept && w_is_mul) begin
      r_mul_a   <= Src_A;
      r_mul_b   <= Src_B;
      r_acc     <= {WIDTH{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_mul_cin <= Flag_C_in;
    end else if (r_state == ST_BUSY) begin
      r_acc     <= w_acc_next;
      r_mul_a   <= r_mul_a << 1;
      r_mul_b   <= r_mul_b >> 1;
      r_cnt     <= r_cnt + CNT_W'(1);
    end
  end
`endif

  // Control state and registered result/flag outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_flags     <= 4'b0000;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (w_is_mul) begin
              r_state     <= ST_BUSY;
              r_out_valid <= 1'b0;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_flags     <= w_flags;
              r_illegal   <= w_illegal;
            end
`else
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_flags     <= w_flags;
            r_illegal   <= w_illegal;
`endif
          end else if ((r_state == ST_DONE) && Out_Ready) begin
            // Result taken with nothing new behind it.
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        ST_BUSY: begin
          if (w_mul_last) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_acc_next;
            r_flags     <= w_mul_flags;
            r_illegal   <= 1'b0;
          end
        end
`endif
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign In_Ready   = w_in_ready;
  assign Out_Valid  = r_out_valid;
  assign ALUResult  = r_result;
  assign ALUFlags   = r_flags;
  assign Op_Illegal = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq (WIDTH=32). A behavioural model computes
// each result with plain signed/unsigned integer arithmetic and tracks the
// expected handshake timing; a negedge compare process checks the DUT on
// every cycle. Directed scenarios plus randomized traffic follow.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int W = 32;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam longint TWO32 = 64'sh1_0000_0000;
  localparam longint MAXS  = 64'sd2147483647;
  localparam longint MINS  = -64'sd2147483648;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         In_Valid = 1'b0;
  logic         In_Ready;
  logic [W-1:0] Src_A = '0;
  logic [W-1:0] Src_B = '0;
  logic [3:0]   ALUControl = 4'h0;
  logic         Flag_C_in = 1'b0;
  logic         Out_Valid;
  logic         Out_Ready = 1'b0;
  logic [W-1:0] ALUResult;
  logic [3:0]   ALUFlags;
  logic         Op_Illegal;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Behavioural model state.
  bit           m_valid = 1'b0;
  logic [W-1:0] m_res = '0;
  logic [3:0]   m_flags = 4'h0;
  bit           m_ill = 1'b0;
  int           m_busy = 0;
  logic [W-1:0] m_pres = '0;
  logic [3:0]   m_pflags = 4'h0;

  alu_seq #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Src_A      (Src_A),
    .Src_B      (Src_B),
    .ALUControl (ALUControl),
    .Flag_C_in  (Flag_C_in),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .ALUResult  (ALUResult),
    .ALUFlags   (ALUFlags),
    .Op_Illegal (Op_Illegal)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from the opcode rules using integer arithmetic.
  function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, output logic [W-1:0] r, output logic [3:0] f,
                                 output bit ill);
    longint ua, ub, sa, sb, ci, us, ss;
    logic c, v;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ci = cin ? 64'sd1 : 64'sd0;
    us = 0; ss = 0; c = cin; v = 1'b0; ill = 1'b0;
    case (op)
      4'b0000: begin us = ua + ub;           c = (us >= TWO32);       ss = sa + sb; end
      4'b0001: begin us = ua - ub;           c = (ua >= ub);          ss = sa - sb; end
      4'b0101: begin us = ua + ub + ci;      c = (us >= TWO32);       ss = sa + sb + ci; end
      4'b0110: begin us = ua - ub - 1 + ci;  c = (ua >= ub + 1 - ci); ss = sa - sb - 1 + ci; end
      4'b0111: begin us = ub - ua;           c = (ub >= ua);          ss = sb - sa; end
      4'b0010: us = ua & ub;
      4'b0011: us = ua | ub;
      4'b0100: us = ua ^ ub;
      4'b1000: begin
        if (MUL_EN) us = ua * ub;
        else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (op inside {4'b0000, 4'b0001, 4'b0101, 4'b0110, 4'b0111})
      v = (ss > MAXS) || (ss < MINS);
    r = ill ? '0 : us[W-1:0];
    f = {r[W-1], (r == '0), c, v};
  endfunction

  function automatic bit exp_in_ready();
    return (m_busy == 0) && (!m_valid || Out_Ready);
  endfunction

  // Advance one clock; the model consumes the inputs the DUT sampled at this edge.
  task automatic tick();
    bit acc;
    logic [W-1:0] r;
    logic [3:0] f;
    bit ill;
    @(posedge CLK);
    if (RESET_N) begin
      acc = In_Valid && exp_in_ready();
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1'b1; m_res = m_pres; m_flags = m_pflags; m_ill = 1'b0;
        end
      end else begin
        if (m_valid && Out_Ready) m_valid = 1'b0;
        if (acc) begin
          ref_op(ALUControl, Src_A, Src_B, Flag_C_in, r, f, ill);
          if (MUL_EN && ALUControl == 4'b1000) begin
            m_busy = W; m_pres = r; m_pflags = f; m_valid = 1'b0;
          end else begin
            m_valid = 1'b1; m_res = r; m_flags = f; m_ill = ill;
          end
        end
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit cin, input bit ordy);
    In_Valid = v; ALUControl = op; Src_A = a; Src_B = b; Flag_C_in = cin; Out_Ready = ordy;
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge CLK) begin
    if (chk_on && RESET_N) begin
      chk("out_valid", {63'd0, Out_Valid}, {63'd0, m_valid});
      chk("in_ready", {63'd0, In_Ready}, {63'd0, exp_in_ready()});
      if (m_valid) begin
        chk("result", {32'd0, ALUResult}, {32'd0, m_res});
        chk("flags", {60'd0, ALUFlags}, {60'd0, m_flags});
        chk("illegal", {63'd0, Op_Illegal}, {63'd0, m_ill});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r;
    logic [3:0] f;
    bit ill;
    int n;
    logic [3:0] ops[10];
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hB};

    // Pin the model with hand-computed values.
    ref_op(4'b0000, 32'h7FFFFFFF, 32'h00000001, 1'b0, r, f, ill);
    chk("pin_add_res", {32'd0, r}, 64'h80000000); chk("pin_add_flg", {60'd0, f}, 64'h9);
    ref_op(4'b0110, 32'h0, 32'h1, 1'b0, r, f, ill);
    chk("pin_sbc_res", {32'd0, r}, 64'hFFFFFFFE); chk("pin_sbc_flg", {60'd0, f}, 64'h8);
    ref_op(4'b0001, 32'h80000000, 32'h1, 1'b0, r, f, ill);
    chk("pin_sub_res", {32'd0, r}, 64'h7FFFFFFF); chk("pin_sub_flg", {60'd0, f}, 64'h3);
    ref_op(4'b0111, 32'h1, 32'h3, 1'b0, r, f, ill);
    chk("pin_rsb_res", {32'd0, r}, 64'h2); chk("pin_rsb_flg", {60'd0, f}, 64'h2);
    ref_op(4'b0101, 32'hFFFFFFFF, 32'h0, 1'b1, r, f, ill);
    chk("pin_adc_flg", {60'd0, f}, 64'h6);
    ref_op(4'b1011, 32'h1234, 32'h5678, 1'b1, r, f, ill);
    chk("pin_ill_flg", {60'd0, f}, 64'h6); chk("pin_ill", {63'd0, ill}, 64'h1);

    // Reset state.
    repeat (2) tick();
    chk("rst_out_valid", {63'd0, Out_Valid}, 64'h0);
    chk("rst_result", {32'd0, ALUResult}, 64'h0);
    chk("rst_flags", {60'd0, ALUFlags}, 64'h0);
    chk("rst_illegal", {63'd0, Op_Illegal}, 64'h0);
    RESET_N = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, In_Ready}, 64'h1);
    chk_on = 1'b1;
    tick();

    // ADD overflow, one-cycle latency.
    drive(1'b1, 4'b0000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("add_valid", {63'd0, Out_Valid}, 64'h1);
    chk("add_res", {32'd0, ALUResult}, 64'h80000000);
    chk("add_flg", {60'd0, ALUFlags}, 64'h9);
    Out_Ready = 1'b1;
    tick();

    // SUB then SBC back-to-back.
    drive(1'b1, 4'b0001, 32'd5, 32'd5, 1'b0, 1'b1);
    tick();
    chk("sub_res", {32'd0, ALUResult}, 64'h0);
    chk("sub_flg", {60'd0, ALUFlags}, 64'h6);
    drive(1'b1, 4'b0110, 32'd0, 32'd1, 1'b0, 1'b1);
    #1;
    chk("b2b_in_ready", {63'd0, In_Ready}, 64'h1);
    tick();
    chk("sbc_valid", {63'd0, Out_Valid}, 64'h1);
    chk("sbc_res", {32'd0, ALUResult}, 64'hFFFFFFFE);
    chk("sbc_flg", {60'd0, ALUFlags}, 64'h8);
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();

    // AND with consumer stalled for three cycles.
    drive(1'b1, 4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b0000, 32'h1, 32'h1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_res", {32'd0, ALUResult}, 64'hF000F000);
      chk("stall_in_ready", {63'd0, In_Ready}, 64'h0);
      tick();
    end
    In_Valid = 1'b0;
    Out_Ready = 1'b1;
    #1;
    chk("stall_release_rdy", {63'd0, In_Ready}, 64'h1);
    tick();
    chk("stall_release_vld", {63'd0, Out_Valid}, 64'h0);

    // Illegal opcode.
    drive(1'b1, 4'b1011, 32'h1234, 32'h5678, 1'b1, 1'b1);
    tick();
    In_Valid = 1'b0;
    chk("ill_res", {32'd0, ALUResult}, 64'h0);
    chk("ill_flg", {60'd0, ALUFlags}, 64'h6);
    chk("ill_flag", {63'd0, Op_Illegal}, 64'h1);
    tick();

`ifdef ALU_SEQ_MUL_EN
    // Multiply latency and result.
    drive(1'b1, 4'b1000, 32'h00010003, 32'h00000005, 1'b0, 1'b1);
    tick();
    drive(1'b1, 4'b0000, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b1);
    n = 1;
    while (!Out_Valid && n < 40) begin
      chk("mul_busy_rdy", {63'd0, In_Ready}, 64'h0);
      tick();
      n++;
    end
    chk("mul_latency", n, 64'd33);
    chk("mul_res", {32'd0, ALUResult}, 64'h0005000F);
    In_Valid = 1'b0;
    tick();

    // Reset during multiply cycle 10.
    drive(1'b1, 4'b1000, 32'h00000007, 32'h00000009, 1'b0, 1'b1);
    tick();
    In_Valid = 1'b0;
    repeat (9) tick();
`else
    // Opcode 1000 is illegal without the multiplier.
    drive(1'b1, 4'b1000, 32'h00010003, 32'h00000005, 1'b1, 1'b1);
    tick();
    In_Valid = 1'b0;
    chk("mul_off_res", {32'd0, ALUResult}, 64'h0);
    chk("mul_off_flg", {60'd0, ALUFlags}, 64'h6);
    chk("mul_off_ill", {63'd0, Op_Illegal}, 64'h1);
    tick();

    // Reset while a result is held.
    drive(1'b1, 4'b0000, 32'h00000007, 32'h00000009, 1'b0, 1'b0);
    tick();
    In_Valid = 1'b0;
`endif
    RESET_N = 1'b0;
    #1;
    chk("rst_mid_valid", {63'd0, Out_Valid}, 64'h0);
    m_valid = 1'b0; m_busy = 0;
    repeat (2) tick();
    RESET_N = 1'b1;
    #1;
    chk("rst_mid_rdy", {63'd0, In_Ready}, 64'h1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Out_Valid) n++;
    end
    chk("rst_no_result", n, 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] a, b;
      case ($urandom_range(0, 5))
        0: a = 32'h0;
        1: a = 32'h7FFFFFFF;
        2: a = 32'h80000000;
        3: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'h00000001;
        2: b = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      drive(($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0) ? 4'b1000 : ops[$urandom_range(0, 9)],
            a, b, $urandom_range(0, 1), ($urandom_range(0, 3) != 0));
      if (ALUControl == 4'b1000 && $urandom_range(0, 3) != 0) ALUControl = 4'b0001;
      tick();
    end
    In_Valid = 1'b0;
    Out_Ready = 1'b1;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU. Handles WIDTH-bit operands and a 4-bit opcode with ARM-style NZCV flags.
- Adds carry-in ops (ADC/SBC), EOR, RSB and an optional iterative multiply.
- Operands enter and results leave through valid/ready handshakes, so the execute stage can stall around multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4)
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width

Ports:
- CLK  in  1  single clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- In_Valid  in  1  operand set valid
- In_Ready  out  1  block can accept operands this cycle
- Src_A  in  WIDTH  operand A
- Src_B  in  WIDTH  operand B
- ALUControl  in  4  opcode
- Flag_C_in  in  1  current C flag (ADC/SBC carry, logic/MUL C pass-through)
- Out_Valid  out  1  result valid
- Out_Ready  in  1  consumer takes result this cycle
- ALUResult  out  WIDTH  registered result
- ALUFlags  out  4  registered {N,Z,C,V}
- Op_Illegal  out  1  result corresponds to an undefined opcode

Behaviour:
- Reset, asynchronous on RESET_N low: state IDLE; Out_Valid=0, ALUResult=0, ALUFlags=0, Op_Illegal=0, counter=0. In_Ready=1 once released.
- Handshakes:
  - Accept when In_Valid & In_Ready. Result transfers when Out_Valid & Out_Ready.
  - ALUResult/ALUFlags/Op_Illegal hold stable while Out_Valid=1 and Out_Ready=0.
- States: IDLE, BUSY (multiply iterating), DONE (result presented).
- In_Ready = (state==IDLE) | (state==DONE & Out_Ready). Back-to-back single-cycle ops therefore give one result per cycle.
- Transitions:
  - IDLE/DONE + accept of a single-cycle op -> DONE; result registered the same edge, so latency is 1 cycle.
  - IDLE/DONE + accept of MUL -> BUSY.
  - BUSY runs WIDTH cycles -> DONE. Accept-to-Out_Valid is WIDTH+1 cycles.
  - DONE & Out_Ready & no accept -> IDLE, Out_Valid=0.
- Opcodes and sums. Sums are formed at WIDTH+1 bits; C = bit WIDTH.
  - 0000 ADD: A+B
  - 0001 SUB: A+~B+1
  - 0010 AND, 0011 ORR, 0100 EOR
  - 0101 ADC: A+B+Cin
  - 0110 SBC: A+~B+Cin
  - 0111 RSB: B+~A+1
  - 1000 MUL (optional)
  - other codes: illegal
- Flags:
  - N = result[WIDTH-1]; Z = (result==0).
  - Arithmetic: C = carry out; for SUB/SBC/RSB, C=1 means no borrow.
  - Overflow: V = (x[MSB]==y[MSB]) & (sum[MSB]!=x[MSB]), where x,y are the adder inputs after inversion.
  - Logic ops and MUL: C = Flag_C_in, V=0.
- Illegal opcode: result 0, flags {0,1,Flag_C_in,0}, Op_Illegal=1 with that result; latency 1.
- Multiply:
  - Unsigned shift-add, one bit of B per cycle, LSB first; accumulator is WIDTH bits, upper product bits are discarded.
  - Inputs are captured at accept, so Src_A/Src_B may change during BUSY.
- Reset mid-BUSY aborts the multiply: no result is produced and the state is IDLE.
- In_Valid while BUSY is ignored (In_Ready=0).

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: opcode 1000 is MUL as above, with BUSY state, counter and accumulator present.
- Undefined: no BUSY logic is built; 1000 is treated as illegal (1-cycle, Op_Illegal=1).

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams (OP_ADD..OP_MUL)
  - state enum (IDLE, BUSY, DONE)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
- Sub-module alu_seq_addsub: combinational WIDTH+1 adder with operand inversion select, carry-in, C and V outputs. Shared by ADD/SUB/ADC/SBC/RSB.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+0x00000001 -> ALUResult 0x80000000, flags N=1 Z=0 C=0 V=1, Out_Valid one cycle after accept.
- SUB 5-5, then SBC 0-1 with Cin=0, back-to-back with Out_Ready=1 -> 0x0/{0,1,1,0} then 0xFFFFFFFE/{1,0,0,0}; In_Ready stays 1, one result per cycle.
- Out_Ready held 0 for 3 cycles after AND 0xF0F0F0F0&0xFF00FF00 -> 0xF000F000 held stable, In_Ready=0, then releases on Out_Ready=1.
- MUL 0x00010003*0x00000005 (macro on) -> 0x0005000F, Out_Valid asserts exactly 33 cycles after accept; In_Ready=0 throughout BUSY.
- Opcode 1011 with Cin=1 -> result 0, flags {0,1,1,0}, Op_Illegal=1. With macro off, opcode 1000 gives the same response.
- RESET_N pulsed low during MUL cycle 10 -> Out_Valid=0 immediately, no result after release, In_Ready=1.
